hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 ID_rs1, ID_rs2  in  5 each: source registers of the instruction in ID.
REQ-003 ID_use_rs1, ID_use_rs2  in  1 each: the ID instruction reads that source.
REQ-004 ID_branch  in  1: the ID instruction is a conditional branch, compared in ID.
REQ-005 ID_jalr  in  1: the ID instruction is a JALR, with its target computed in ID.
REQ-006 ID_taken  in  1: a branch, JAL or JALR in ID redirects the PC.
REQ-007 EX_rd  in  5; EX_regwrite  in  1; EX_memread  in  1: destination and control of the instruction in EX.
REQ-008 M_rd  in  5; M_memread  in  1: destination and load flag of the instruction in MEM.
REQ-009 IM_stall, DM_stall  in  1 each: instruction memory or data memory is waiting.
REQ-010 cnt_clr  in  1: synchronous clear of the performance counters.
REQ-011 pc_en, ifid_en, exm_en, mwb_en  out  1 each: PC and pipeline-register write enables.
REQ-012 ifid_flush  out  1: zero the IF/ID register; idex_bubble  out  1: insert a NOP into ID/EX.
REQ-013 stall_cnt, freeze_cnt, flush_cnt  out  16 each: saturating event counters.

Function
REQ-014 mem_wait = IM_stall | DM_stall.
REQ-015 load_use = EX_memread & EX_rd!=0 & ((ID_use_rs1 & EX_rd==ID_rs1) | (ID_use_rs2 & EX_rd==ID_rs2)).
REQ-016 br_dep_ex = (ID_branch|ID_jalr) & EX_regwrite & EX_rd!=0 & EX_rd matches a used ID source.
REQ-017 br_dep_m = (ID_branch|ID_jalr) & M_memread & M_rd!=0 & M_rd matches a used ID source.
REQ-018 hazard = load_use | br_dep_ex | br_dep_m, where register x0 never creates a hazard.
REQ-019 Outputs SHALL be combinational from the current state and inputs, and all counters SHALL be registered.
REQ-020 The FSM SHALL have three states: RUN, FREEZE and FLUSH_PEND, with RUN entered on reset.
REQ-021 RUN with mem_wait: all enables 0, no flush or bubble; next state FREEZE, or FLUSH_PEND if ID_taken & !hazard.
REQ-022 RUN with !mem_wait & hazard: pc_en=0, ifid_en=0, idex_bubble=1, exm_en=1, mwb_en=1, ifid_flush=0; stay in RUN.
REQ-023 RUN with !mem_wait & !hazard: all enables 1; ifid_flush=ID_taken; stay in RUN.
REQ-024 A load feeding a branch SHALL produce exactly 2 stall cycles: the br_dep_ex cycle followed by the br_dep_m cycle.
REQ-025 An ALU result feeding a branch SHALL produce 1 stall cycle, then use the M-to-ID forward.
REQ-026 FREEZE: all enables 0 while mem_wait; when mem_wait falls, the outputs SHALL follow the RUN rules in that cycle and the FSM SHALL return to RUN.
REQ-027 FLUSH_PEND: all enables 0 while mem_wait; in the first cycle with !mem_wait, ifid_flush=1 with all enables 1, then the FSM SHALL return to RUN.
REQ-028 ID_taken SHALL be ignored while hazard=1, so no flush occurs on a stalled branch.
REQ-029 mem_wait SHALL dominate hazard and ID_taken in every state.
REQ-030 stall_cnt SHALL increment each cycle REQ-022 applies.
REQ-031 freeze_cnt SHALL increment each cycle all enables are 0 due to mem_wait.
REQ-032 flush_cnt SHALL increment each cycle ifid_flush=1.
REQ-033 Counters SHALL saturate at 16'hFFFF, and cnt_clr SHALL zero them, taking priority over increment.

Reset
REQ-034 On rst=1, asynchronously: state=RUN and all counters=0.
REQ-035 During reset, outputs SHALL be pc_en=ifid_en=exm_en=mwb_en=1 and ifid_flush=idex_bubble=0.
REQ-036 Reset asserted in FREEZE or FLUSH_PEND SHALL discard the pending flush.
REQ-037 The first rising edge after rst falls SHALL evaluate the RUN rules.

Verification
REQ-038 Load-use: EX_memread=1, EX_rd=5, ID_rs1=5, ID_use_rs1=1 -> for one cycle pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt=1.
REQ-039 Load-to-branch: EX load with rd=7; ID_branch=1, ID_rs2=7 -> 2 consecutive stall cycles, then all enables 1; stall_cnt=2.
REQ-040 x0: EX_memread=1, EX_rd=0, ID_rs1=0 -> no stall; all enables 1.
REQ-041 Taken branch during IM_stall for 3 cycles -> enables 0 for 3 cycles, then ifid_flush=1 for exactly one cycle; freeze_cnt=3, flush_cnt=1.
REQ-042 Hazard plus DM_stall together -> freeze only, idex_bubble=0; after DM_stall falls, one stall cycle follows.
REQ-043 stall_cnt preloaded to 16'hFFFF plus another stall -> stays 16'hFFFF; cnt_clr=1 -> 0; rst in FLUSH_PEND -> no flush after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, memory-wait
// freezes, and a deferred flush for redirects that arrive during a freeze.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic        ID_use_rs1,
    input  logic        ID_use_rs2,
    input  logic        ID_branch,
    input  logic        ID_jalr,
    input  logic        ID_taken,
    input  logic [4:0]  EX_rd,
    input  logic        EX_regwrite,
    input  logic        EX_memread,
    input  logic [4:0]  M_rd,
    input  logic        M_memread,
    input  logic        IM_stall,
    input  logic        DM_stall,
    input  logic        cnt_clr,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        exm_en,
    output logic        mwb_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [15:0] stall_cnt,
    output logic [15:0] freeze_cnt,
    output logic [15:0] flush_cnt
);

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FREEZE     = 2'd1,
        FLUSH_PEND = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_wait, ex_match, m_match, is_ctl;
    logic load_use, br_dep_ex, br_dep_m, hazard;
    logic stall_ev, freeze_ev;

    // x0 is hard-wired zero, so a destination of 0 never matches a source.
    function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic use1,
                                       input logic use2);
        return (rd != 5'd0) && ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic ev);
        return (ev && (cnt != {CNT_W{1'b1}})) ? cnt + 1'b1 : cnt;
    endfunction

    assign mem_wait  = IM_stall | DM_stall;
    assign ex_match  = src_match(EX_rd, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2);
    assign m_match   = src_match(M_rd, ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2);
    assign is_ctl    = ID_branch | ID_jalr;
    assign load_use  = EX_memread & ex_match;
    assign br_dep_ex = is_ctl & EX_regwrite & ex_match;
    assign br_dep_m  = is_ctl & M_memread & m_match;
    assign hazard    = load_use | br_dep_ex | br_dep_m;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        exm_en      = 1'b1;
        mwb_en      = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_ev    = 1'b0;
        freeze_ev   = 1'b0;
        state_d     = state_q;
        if (rst) begin
            state_d = RUN;
        end else if (mem_wait) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            exm_en    = 1'b0;
            mwb_en    = 1'b0;
            freeze_ev = 1'b1;
            if (state_q == RUN)
                state_d = (ID_taken && !hazard) ? FLUSH_PEND : FREEZE;
        end else if (state_q == FLUSH_PEND) begin
            ifid_flush = 1'b1;
            state_d    = RUN;
        end else begin
            // RUN, or FREEZE releasing: the RUN rules apply this cycle.
            state_d = RUN;
            if (hazard) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                stall_ev    = 1'b1;
            end else begin
                ifid_flush = ID_taken;
            end
        end
    end

    always_comb begin
        if (cnt_clr) begin
            stall_cnt_d  = '0;
            freeze_cnt_d = '0;
            flush_cnt_d  = '0;
        end else begin
            stall_cnt_d  = sat_inc(stall_cnt_q, stall_ev);
            freeze_cnt_d = sat_inc(freeze_cnt_q, freeze_ev);
            flush_cnt_d  = sat_inc(flush_cnt_q, ifid_flush);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of single-cycle RUN vectors plus
// hand-written multi-cycle sequences for freeze, flush, saturation and reset.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs1, ID_rs2, EX_rd, M_rd;
    logic        ID_use_rs1, ID_use_rs2, ID_branch, ID_jalr, ID_taken;
    logic        EX_regwrite, EX_memread, M_memread, IM_stall, DM_stall, cnt_clr;
    logic        pc_en, ifid_en, exm_en, mwb_en, ifid_flush, idex_bubble;
    logic [15:0] stall_cnt, freeze_cnt, flush_cnt;
    logic [5:0]  outs;

    int nvec  = 0;
    int nfail = 0;

    // {pc_en, ifid_en, exm_en, mwb_en, ifid_flush, idex_bubble}
    localparam logic [5:0] O_RUN   = 6'b111100;
    localparam logic [5:0] O_STALL = 6'b001101;
    localparam logic [5:0] O_FRZ   = 6'b000000;
    localparam logic [5:0] O_FLUSH = 6'b111110;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, ex_rd, m_rd;
        logic       use1, use2, br, jalr, taken, ex_rw, ex_mr, m_mr;
        logic [5:0] exp;
    } vec_t;

    vec_t vt[13];

    always #5 clk = ~clk;

    assign outs = {pc_en, ifid_en, exm_en, mwb_en, ifid_flush, idex_bubble};

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .ID_branch(ID_branch), .ID_jalr(ID_jalr), .ID_taken(ID_taken),
        .EX_rd(EX_rd), .EX_regwrite(EX_regwrite), .EX_memread(EX_memread),
        .M_rd(M_rd), .M_memread(M_memread),
        .IM_stall(IM_stall), .DM_stall(DM_stall), .cnt_clr(cnt_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .exm_en(exm_en), .mwb_en(mwb_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
    );

    function automatic vec_t mk(input string nm, input logic [4:0] rs1, input logic use1,
                                input logic [4:0] rs2, input logic use2, input logic br,
                                input logic jalr, input logic taken, input logic [4:0] ex_rd,
                                input logic ex_rw, input logic ex_mr, input logic [4:0] m_rd,
                                input logic m_mr, input logic [5:0] exp);
        vec_t v;
        v.name = nm; v.rs1 = rs1; v.use1 = use1; v.rs2 = rs2; v.use2 = use2;
        v.br = br; v.jalr = jalr; v.taken = taken; v.ex_rd = ex_rd; v.ex_rw = ex_rw;
        v.ex_mr = ex_mr; v.m_rd = m_rd; v.m_mr = m_mr; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        ID_rs1 = v.rs1; ID_use_rs1 = v.use1; ID_rs2 = v.rs2; ID_use_rs2 = v.use2;
        ID_branch = v.br; ID_jalr = v.jalr; ID_taken = v.taken;
        EX_rd = v.ex_rd; EX_regwrite = v.ex_rw; EX_memread = v.ex_mr;
        M_rd = v.m_rd; M_memread = v.m_mr;
    endtask

    task automatic neutral();
        apply(mk("idle", 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, O_RUN));
        IM_stall = 1'b0; DM_stall = 1'b0;
    endtask

    // Inputs are already driven at posedge+1; check mid-cycle, then advance.
    task automatic cyc(input string nm, input logic [5:0] exp);
        #2;
        chk(nm, {10'd0, outs}, {10'd0, exp});
        @(posedge clk); #1;
    endtask

    task automatic clear_cnts();
        neutral();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
    endtask

    initial begin
        int exp_stall, exp_flush;
        vec_t lu5;
        vt[0]  = mk("idle",        5'd0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, O_RUN);
        vt[1]  = mk("load_use_rs1", 5'd5, 1, 5'd0, 0, 0, 0, 0, 5'd5, 1, 1, 5'd0, 0, O_STALL);
        vt[2]  = mk("lu_rs2_unused", 5'd1, 1, 5'd5, 0, 0, 0, 0, 5'd5, 1, 1, 5'd0, 0, O_RUN);
        vt[3]  = mk("load_x0",     5'd0, 1, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1, 5'd0, 0, O_RUN);
        vt[4]  = mk("alu_to_br",   5'd3, 1, 5'd0, 0, 1, 0, 0, 5'd3, 1, 0, 5'd0, 0, O_STALL);
        vt[5]  = mk("alu_fwd",     5'd3, 1, 5'd0, 0, 0, 0, 0, 5'd3, 1, 0, 5'd0, 0, O_RUN);
        vt[6]  = mk("br_taken",    5'd1, 1, 5'd0, 0, 1, 0, 1, 5'd2, 1, 0, 5'd0, 0, O_FLUSH);
        vt[7]  = mk("taken_hazard", 5'd0, 0, 5'd4, 1, 1, 0, 1, 5'd4, 1, 0, 5'd0, 0, O_STALL);
        vt[8]  = mk("jalr_m_load", 5'd9, 1, 5'd0, 0, 0, 1, 1, 5'd0, 0, 0, 5'd9, 1, O_STALL);
        vt[9]  = mk("m_load_alu",  5'd9, 1, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd9, 1, O_RUN);
        vt[10] = mk("br_m_x0",     5'd0, 1, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0, 5'd0, 1, O_RUN);
        vt[11] = mk("jal_taken",   5'd6, 1, 5'd0, 0, 0, 0, 1, 5'd6, 1, 0, 5'd0, 0, O_FLUSH);
        vt[12] = mk("br_m_noload", 5'd0, 0, 5'd8, 1, 1, 0, 0, 5'd0, 0, 0, 5'd8, 0, O_RUN);
        lu5    = vt[1];

        // Reset: outputs forced to RUN-idle even with a hazard on the inputs.
        cnt_clr = 1'b0; IM_stall = 1'b1; DM_stall = 1'b0;
        apply(lu5);
        rst = 1'b1;
        #3;
        chk("reset_outs", {10'd0, outs}, {10'd0, O_RUN});
        chk("reset_stall_cnt", stall_cnt, 16'd0);
        chk("reset_freeze_cnt", freeze_cnt, 16'd0);
        @(posedge clk); #1;
        neutral();
        rst = 1'b0;

        exp_stall = 0; exp_flush = 0;
        foreach (vt[i]) begin
            apply(vt[i]);
            exp_stall += int'(vt[i].exp[0]);
            exp_flush += int'(vt[i].exp[1]);
            cyc(vt[i].name, vt[i].exp);
        end
        chk("table_stall_cnt", stall_cnt, 16'(exp_stall));
        chk("table_flush_cnt", flush_cnt, 16'(exp_flush));
        chk("table_freeze_cnt", freeze_cnt, 16'd0);
        cnt_clr = 1'b1; apply(lu5);
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_over_inc", stall_cnt, 16'd0);

        // Load feeding a branch: EX-stage stall then MEM-stage stall.
        clear_cnts();
        apply(mk("lb1", 5'd0, 0, 5'd7, 1, 1, 0, 0, 5'd7, 1, 1, 5'd0, 0, O_STALL));
        cyc("ld_br_c1", O_STALL);
        apply(mk("lb2", 5'd0, 0, 5'd7, 1, 1, 0, 0, 5'd0, 0, 0, 5'd7, 1, O_STALL));
        cyc("ld_br_c2", O_STALL);
        neutral(); ID_branch = 1'b1; ID_rs2 = 5'd7; ID_use_rs2 = 1'b1;
        cyc("ld_br_c3", O_RUN);
        chk("ld_br_stall_cnt", stall_cnt, 16'd2);

        // Taken branch under a 3-cycle IM stall: freeze, then one deferred flush.
        clear_cnts();
        ID_branch = 1'b1; ID_taken = 1'b1; IM_stall = 1'b1;
        for (int i = 0; i < 3; i++) cyc("im_freeze", O_FRZ);
        neutral();
        cyc("im_flush", O_FLUSH);
        cyc("im_after", O_RUN);
        chk("im_freeze_cnt", freeze_cnt, 16'd3);
        chk("im_flush_cnt", flush_cnt, 16'd1);

        // Hazard with DM stall: freeze only, one stall once memory is ready.
        clear_cnts();
        apply(lu5); DM_stall = 1'b1;
        cyc("dm_freeze", O_FRZ);
        DM_stall = 1'b0;
        cyc("dm_release_stall", O_STALL);
        neutral();
        cyc("dm_after", O_RUN);
        chk("dm_stall_cnt", stall_cnt, 16'd1);
        chk("dm_freeze_cnt", freeze_cnt, 16'd1);

        // Saturation of stall_cnt, then clear.
        clear_cnts();
        apply(lu5);
        repeat (65535) @(posedge clk);
        #1;
        chk("sat_reach", stall_cnt, 16'hFFFF);
        @(posedge clk); #1;
        chk("sat_hold", stall_cnt, 16'hFFFF);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("sat_clr", stall_cnt, 16'd0);

        // Reset while a flush is pending discards it.
        neutral(); ID_branch = 1'b1; ID_taken = 1'b1; IM_stall = 1'b1;
        cyc("fp_enter", O_FRZ);
        rst = 1'b1;
        #1;
        chk("fp_rst_outs", {10'd0, outs}, {10'd0, O_RUN});
        chk("fp_rst_freeze_cnt", freeze_cnt, 16'd0);
        @(posedge clk); #1;
        neutral();
        rst = 1'b0;
        cyc("fp_no_flush", O_RUN);
        chk("fp_flush_cnt", flush_cnt, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
